// File: rtl/lb_arbiter.sv
// lb_arbiter: shares one local-bus slave between two masters (M0 = host path,
// M1 = on-chip sequencer). Each master has a one-deep pending slot; a small FSM
// issues one transaction at a time, routes read data back, and guards reads
// with a timeout so a silent slave never hangs a master.
//
// Handshake: there is no backpressure anywhere. A master strobe (wr or rd) is a
// one-cycle pulse accepted only when that master's slot is empty (busy low);
// otherwise it is dropped and err_ovf[n] pulses. Slave strobes lb_wr/lb_rd are
// one-cycle pulses; lb_rd_rdy is a one-cycle reply pulse honoured only while
// the FSM waits for it. mN_rd_rdy is a one-cycle pulse qualifying mN_rd_d.
module lb_arbiter #(
  parameter bit          RR_EN    = 1'b1,
  parameter int unsigned TMO_CYC  = 255,
  parameter logic [31:0] TMO_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_wr,
  input  logic        m0_rd,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wr_d,
  output logic [31:0] m0_rd_d,
  output logic        m0_rd_rdy,
  output logic        m0_busy,
  input  logic        m1_wr,
  input  logic        m1_rd,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wr_d,
  output logic [31:0] m1_rd_d,
  output logic        m1_rd_rdy,
  output logic        m1_busy,
  output logic        lb_wr,
  output logic        lb_rd,
  output logic [31:0] lb_addr,
  output logic [31:0] lb_wr_d,
  input  logic [31:0] lb_rd_d,
  input  logic        lb_rd_rdy,
  output logic [1:0]  err_ovf,
  output logic        err_tmo,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  // Timeout fires on the TMO_CYC-th RD_WAIT cycle without a reply.
  localparam logic [16:0] TMO_LIM = 17'(TMO_CYC);

  // Per-master views of the strobe inputs, index = master number.
  logic [1:0]  strb_wr;
  logic [1:0]  strb_rd;
  logic [31:0] strb_addr [2];
  logic [31:0] strb_data [2];

  assign strb_wr      = {m1_wr, m0_wr};
  assign strb_rd      = {m1_rd, m0_rd};
  assign strb_addr[0] = m0_addr;
  assign strb_addr[1] = m1_addr;
  assign strb_data[0] = m0_wr_d;
  assign strb_data[1] = m1_wr_d;

  // Pending slots.
  logic [1:0]  vld_q;
  logic [1:0]  op_wr_q;
  logic [31:0] addr_q [2];
  logic [31:0] data_q [2];
  logic [1:0]  ovf_q;
  logic [1:0]  clr;

  // FSM and datapath registers.
  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic        win;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] lb_addr_q, lb_addr_d;
  logic [31:0] lb_wdat_q, lb_wdat_d;
  logic        ret_en;
  logic [31:0] ret_data;
  logic [1:0]  rdy_q, rdy_d;
  logic        tmo_q, tmo_d;
  logic [31:0] rd_d_q [2];

  // Slot capture: a strobe loads an empty slot; a strobe into a full slot (including
  // the cycle it is being freed) or wr+rd together raises the overflow pulse.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (reset) begin
        vld_q[n]   <= 1'b0;
        op_wr_q[n] <= 1'b0;
        addr_q[n]  <= '0;
        data_q[n]  <= '0;
        ovf_q[n]   <= 1'b0;
      end else begin
        ovf_q[n] <= (strb_wr[n] | strb_rd[n]) & (vld_q[n] | (strb_wr[n] & strb_rd[n]));
        if (clr[n]) begin
          vld_q[n] <= 1'b0;
        end else if (!vld_q[n] && (strb_wr[n] || strb_rd[n])) begin
          vld_q[n]   <= 1'b1;
          op_wr_q[n] <= strb_wr[n];
          addr_q[n]  <= strb_addr[n];
          data_q[n]  <= strb_data[n];
        end
      end
    end
  end

  // Arbitration: a lone pending master wins; on a tie round-robin favours the
  // master not granted last, fixed priority favours M0.
  always_comb begin
    win = 1'b0;
    if (vld_q[0] && vld_q[1]) begin
      win = RR_EN ? ~last_q : 1'b0;
    end else begin
      win = vld_q[1];
    end
  end

  // Next-state logic: issue, single-cycle strobes, read wait with reply or timeout.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    lb_addr_d = lb_addr_q;
    lb_wdat_d = lb_wdat_q;
    clr       = 2'b00;
    ret_en    = 1'b0;
    ret_data  = lb_rd_d;
    rdy_d     = 2'b00;
    tmo_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|vld_q) begin
          gnt_d     = win;
          last_d    = win;
          lb_addr_d = addr_q[win];
          lb_wdat_d = data_q[win];
          state_d   = op_wr_q[win] ? S_WR : S_RD;
        end
      end
      S_WR: begin
        clr[gnt_q] = 1'b1;
        state_d    = S_IDLE;
      end
      S_RD: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lb_rd_rdy) begin
          ret_en     = 1'b1;
          ret_data   = lb_rd_d;
          rdy_d[gnt_q] = 1'b1;
          clr[gnt_q] = 1'b1;
          state_d    = S_IDLE;
        end else if (({1'b0, cnt_q} + 17'd1) == TMO_LIM) begin
          ret_en     = 1'b1;
          ret_data   = TMO_DATA;
          rdy_d[gnt_q] = 1'b1;
          tmo_d      = 1'b1;
          clr[gnt_q] = 1'b1;
          state_d    = S_IDLE;
        end else begin
          cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, grant bookkeeping, timeout counter and slave address/data latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b0;
      cnt_q     <= '0;
      lb_addr_q <= '0;
      lb_wdat_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      lb_addr_q <= lb_addr_d;
      lb_wdat_q <= lb_wdat_d;
    end
  end

  // Read return: only the granted master's data register updates and pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdy_q  <= 2'b00;
      tmo_q  <= 1'b0;
      rd_d_q <= '{32'h0, 32'h0};
    end else begin
      rdy_q <= rdy_d;
      tmo_q <= tmo_d;
      if (ret_en) begin
        rd_d_q[gnt_q] <= ret_data;
      end
    end
  end

  assign lb_wr     = (state_q == S_WR);
  assign lb_rd     = (state_q == S_RD);
  assign lb_addr   = lb_addr_q;
  assign lb_wr_d   = lb_wdat_q;
  assign m0_rd_d   = rd_d_q[0];
  assign m1_rd_d   = rd_d_q[1];
  assign m0_rd_rdy = rdy_q[0];
  assign m1_rd_rdy = rdy_q[1];
  assign m0_busy   = vld_q[0];
  assign m1_busy   = vld_q[1];
  assign err_ovf   = ovf_q;
  assign err_tmo   = tmo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lb_arbiter.sv
// tb_lb_arbiter: directed scenarios for lb_arbiter. Expected bus events are
// queued when stimulus is issued; negedge monitors pop and compare them.
module tb_lb_arbiter;

  localparam int EW = 68;
  localparam logic [2:0] K_OVF = 3'd1;
  localparam logic [2:0] K_WR  = 3'd2;
  localparam logic [2:0] K_RD  = 3'd3;
  localparam logic [2:0] K_RET = 3'd4;
  localparam logic [2:0] K_TMO = 3'd5;

  logic clk = 1'b0;
  logic reset = 1'b1;

  // Instance a: round-robin, short timeout.
  logic        m0_wr = 0, m0_rd = 0, m1_wr = 0, m1_rd = 0;
  logic [31:0] m0_addr = 0, m0_wr_d = 0, m1_addr = 0, m1_wr_d = 0;
  logic [31:0] m0_rd_d, m1_rd_d, lb_addr, lb_wr_d;
  logic        m0_rd_rdy, m1_rd_rdy, m0_busy, m1_busy, lb_wr, lb_rd, err_tmo;
  logic [31:0] lb_rd_d = 0;
  logic        lb_rd_rdy = 0;
  logic [1:0]  err_ovf, dbg_state;

  // Instance b: fixed priority, slave never answers.
  logic        b_m0_rd = 0, b_m1_rd = 0;
  logic [31:0] b_m0_addr = 0, b_m1_addr = 0;
  logic [31:0] b_m0_rd_d, b_m1_rd_d, b_lb_addr, b_lb_wr_d;
  logic        b_m0_rd_rdy, b_m1_rd_rdy, b_m0_busy, b_m1_busy, b_lb_wr, b_lb_rd, b_err_tmo;
  logic [1:0]  b_err_ovf, b_dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp1_q[$];

  lb_arbiter #(.RR_EN(1'b1), .TMO_CYC(8), .TMO_DATA(32'hDEADBEEF)) u_a (
    .clk(clk), .reset(reset),
    .m0_wr(m0_wr), .m0_rd(m0_rd), .m0_addr(m0_addr), .m0_wr_d(m0_wr_d),
    .m0_rd_d(m0_rd_d), .m0_rd_rdy(m0_rd_rdy), .m0_busy(m0_busy),
    .m1_wr(m1_wr), .m1_rd(m1_rd), .m1_addr(m1_addr), .m1_wr_d(m1_wr_d),
    .m1_rd_d(m1_rd_d), .m1_rd_rdy(m1_rd_rdy), .m1_busy(m1_busy),
    .lb_wr(lb_wr), .lb_rd(lb_rd), .lb_addr(lb_addr), .lb_wr_d(lb_wr_d),
    .lb_rd_d(lb_rd_d), .lb_rd_rdy(lb_rd_rdy),
    .err_ovf(err_ovf), .err_tmo(err_tmo), .dbg_state(dbg_state)
  );

  lb_arbiter #(.RR_EN(1'b0), .TMO_CYC(8), .TMO_DATA(32'hDEADBEEF)) u_b (
    .clk(clk), .reset(reset),
    .m0_wr(1'b0), .m0_rd(b_m0_rd), .m0_addr(b_m0_addr), .m0_wr_d(32'h0),
    .m0_rd_d(b_m0_rd_d), .m0_rd_rdy(b_m0_rd_rdy), .m0_busy(b_m0_busy),
    .m1_wr(1'b0), .m1_rd(b_m1_rd), .m1_addr(b_m1_addr), .m1_wr_d(32'h0),
    .m1_rd_d(b_m1_rd_d), .m1_rd_rdy(b_m1_rd_rdy), .m1_busy(b_m1_busy),
    .lb_wr(b_lb_wr), .lb_rd(b_lb_rd), .lb_addr(b_lb_addr), .lb_wr_d(b_lb_wr_d),
    .lb_rd_d(32'h0), .lb_rd_rdy(1'b0),
    .err_ovf(b_err_ovf), .err_tmo(b_err_tmo), .dbg_state(b_dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  function automatic logic [EW-1:0] mk(input logic [2:0] k, input logic id,
                                       input logic [31:0] a, input logic [31:0] d);
    return {k, id, a, d};
  endfunction

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic mon(input bit which, input logic [EW-1:0] ev, input string name);
    logic [EW-1:0] e;
    if ((which ? exp1_q.size() : exp_q.size()) == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got unexpected event %h required none", name, ev);
    end else begin
      e = which ? exp1_q.pop_front() : exp_q.pop_front();
      chk(name, ev, e);
    end
  endtask

  // Scoreboard monitor, instance a. Same-cycle events are checked in this order.
  always @(negedge clk) begin
    if (err_ovf[0]) mon(1'b0, mk(K_OVF, 1'b0, 32'h0, 32'h0), "a_ovf0");
    if (err_ovf[1]) mon(1'b0, mk(K_OVF, 1'b1, 32'h0, 32'h0), "a_ovf1");
    if (lb_wr)      mon(1'b0, mk(K_WR, 1'b0, lb_addr, lb_wr_d), "a_lb_wr");
    if (lb_rd)      mon(1'b0, mk(K_RD, 1'b0, lb_addr, 32'h0), "a_lb_rd");
    if (m0_rd_rdy)  mon(1'b0, mk(K_RET, 1'b0, 32'h0, m0_rd_d), "a_ret0");
    if (m1_rd_rdy)  mon(1'b0, mk(K_RET, 1'b1, 32'h0, m1_rd_d), "a_ret1");
    if (err_tmo)    mon(1'b0, mk(K_TMO, 1'b0, 32'h0, 32'h0), "a_tmo");
  end

  // Scoreboard monitor, instance b.
  always @(negedge clk) begin
    if (b_lb_rd)     mon(1'b1, mk(K_RD, 1'b0, b_lb_addr, 32'h0), "b_lb_rd");
    if (b_m0_rd_rdy) mon(1'b1, mk(K_RET, 1'b0, 32'h0, b_m0_rd_d), "b_ret0");
    if (b_m1_rd_rdy) mon(1'b1, mk(K_RET, 1'b1, 32'h0, b_m1_rd_d), "b_ret1");
  end

  // Driver: one-cycle strobes on instance a; called and returns at posedge+1.
  task automatic drive(input logic [1:0] wr, input logic [1:0] rd,
                       input logic [31:0] a0, input logic [31:0] d0,
                       input logic [31:0] a1, input logic [31:0] d1);
    m0_wr = wr[0]; m0_rd = rd[0]; m0_addr = a0; m0_wr_d = d0;
    m1_wr = wr[1]; m1_rd = rd[1]; m1_addr = a1; m1_wr_d = d1;
    @(posedge clk); #1;
    m0_wr = 1'b0; m0_rd = 1'b0; m1_wr = 1'b0; m1_rd = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Poll for lb_rd on instance a with a cycle budget.
  task automatic wait_rd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (lb_rd) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL wait_lb_rd: got no lb_rd within 40 cycles required lb_rd");
    end
  endtask

  // Slave model: reply n cycles after the lb_rd cycle; returns one cycle after rdy.
  task automatic slave_reply(input int n, input logic [31:0] d);
    bit ok;
    wait_rd(ok);
    if (ok) begin
      repeat (n) @(posedge clk);
      #1;
      lb_rd_d = d;
      lb_rd_rdy = 1'b1;
      @(posedge clk); #1;
      lb_rd_rdy = 1'b0;
    end
  endtask

  initial begin
    bit ok;
    // Reset.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", EW'(|{m0_rd_d, m0_rd_rdy, m0_busy, m1_rd_d, m1_rd_rdy, m1_busy,
                            lb_wr, lb_rd, lb_addr, lb_wr_d, err_ovf, err_tmo}), '0);
    chk("reset_state", EW'(dbg_state), EW'(2'd0));
    reset = 1'b0;
    settle(2);

    // 1: M0 write, latency and busy timing.
    exp_q.push_back(mk(K_WR, 1'b0, 32'h10, 32'hA5A5A5A5));
    drive(2'b00 | 2'b01, 2'b00, 32'h10, 32'hA5A5A5A5, 32'h0, 32'h0);
    chk("t1_busy_k1", EW'({m0_busy, lb_wr}), EW'(2'b10));
    settle(1);
    chk("t1_lbwr_k2", EW'({lb_wr, lb_addr, lb_wr_d}), EW'({1'b1, 32'h10, 32'hA5A5A5A5}));
    settle(1);
    chk("t1_busy_k3", EW'({m0_busy, lb_wr}), EW'(2'b00));
    settle(3);

    // 2: M0 read, slave answers three cycles after lb_rd.
    exp_q.push_back(mk(K_RD, 1'b0, 32'h20, 32'h0));
    exp_q.push_back(mk(K_RET, 1'b0, 32'h0, 32'h12345678));
    drive(2'b00, 2'b01, 32'h20, 32'h0, 32'h0, 32'h0);
    slave_reply(3, 32'h12345678);
    chk("t2_ret", EW'({m0_rd_rdy, m1_rd_rdy, m0_rd_d}), EW'({2'b10, 32'h12345678}));
    settle(1);
    chk("t2_pulse_end", EW'({m0_rd_rdy, m0_busy}), EW'(2'b00));
    settle(3);

    // 3: simultaneous reads after an M0 grant -> M1 first, then M0.
    exp_q.push_back(mk(K_RD, 1'b0, 32'h31, 32'h0));
    exp_q.push_back(mk(K_RET, 1'b1, 32'h0, 32'h11110001));
    exp_q.push_back(mk(K_RD, 1'b0, 32'h30, 32'h0));
    exp_q.push_back(mk(K_RET, 1'b0, 32'h0, 32'h22220002));
    drive(2'b00, 2'b11, 32'h30, 32'h0, 32'h31, 32'h0);
    slave_reply(1, 32'h11110001);
    chk("t3_m1_ret_hold_m0", EW'({m1_rd_rdy, m0_rd_rdy, m1_rd_d, m0_rd_d}),
        EW'({2'b10, 32'h11110001, 32'h12345678}));
    slave_reply(2, 32'h22220002);
    settle(3);

    // 4: M1 read with no reply -> timeout data 8 cycles after lb_rd, late reply ignored.
    exp_q.push_back(mk(K_RD, 1'b0, 32'h50, 32'h0));
    exp_q.push_back(mk(K_RET, 1'b1, 32'h0, 32'hDEADBEEF));
    exp_q.push_back(mk(K_TMO, 1'b0, 32'h0, 32'h0));
    drive(2'b00, 2'b10, 32'h0, 32'h0, 32'h50, 32'h0);
    wait_rd(ok);
    settle(8);
    chk("t4_not_early", EW'({m1_rd_rdy, err_tmo}), EW'(2'b00));
    settle(1);
    chk("t4_tmo", EW'({m1_rd_rdy, err_tmo, m1_rd_d}), EW'({2'b11, 32'hDEADBEEF}));
    settle(1);
    lb_rd_d = 32'h55555555;
    lb_rd_rdy = 1'b1;
    settle(1);
    lb_rd_rdy = 1'b0;
    settle(2);
    chk("t4_late_ignored", EW'({dbg_state, m1_rd_d}), EW'({2'd0, 32'hDEADBEEF}));

    // 5a: second M1 strobe while slot full.
    exp_q.push_back(mk(K_OVF, 1'b1, 32'h0, 32'h0));
    exp_q.push_back(mk(K_WR, 1'b0, 32'h60, 32'h00000006));
    drive(2'b10, 2'b00, 32'h0, 32'h0, 32'h60, 32'h6);
    drive(2'b00, 2'b10, 32'h0, 32'h0, 32'h61, 32'h0);
    settle(4);
    // 5b: M1 wr+rd together -> write kept, read dropped.
    exp_q.push_back(mk(K_OVF, 1'b1, 32'h0, 32'h0));
    exp_q.push_back(mk(K_WR, 1'b0, 32'h70, 32'h00000007));
    drive(2'b10, 2'b10, 32'h0, 32'h0, 32'h70, 32'h7);
    settle(4);
    // 5c: strobe in the cycle the slot is freed is dropped.
    exp_q.push_back(mk(K_WR, 1'b0, 32'h80, 32'h00000008));
    exp_q.push_back(mk(K_OVF, 1'b0, 32'h0, 32'h0));
    drive(2'b01, 2'b00, 32'h80, 32'h8, 32'h0, 32'h0);
    settle(1);
    drive(2'b00, 2'b01, 32'h81, 32'h0, 32'h0, 32'h0);
    settle(4);
    chk("t5_idle", EW'({m0_busy, m1_busy, dbg_state}), EW'(4'b0000));

    // 6: reset in RD_WAIT abandons the read.
    exp_q.push_back(mk(K_RD, 1'b0, 32'h90, 32'h0));
    drive(2'b00, 2'b01, 32'h90, 32'h0, 32'h0, 32'h0);
    wait_rd(ok);
    settle(2);
    chk("t6_in_wait", EW'(dbg_state), EW'(2'd3));
    reset = 1'b1;
    settle(1);
    reset = 1'b0;
    chk("t6_reset_outs", EW'(|{m0_rd_d, m0_rd_rdy, m0_busy, m1_rd_d, m1_rd_rdy, m1_busy,
                               lb_wr, lb_rd, lb_addr, lb_wr_d, err_ovf, err_tmo, dbg_state}), '0);
    lb_rd_d = 32'h77777777;
    lb_rd_rdy = 1'b1;
    settle(1);
    lb_rd_rdy = 1'b0;
    settle(3);

    // 3b: fixed priority instance -> M0 served first (both time out).
    exp1_q.push_back(mk(K_RD, 1'b0, 32'h40, 32'h0));
    exp1_q.push_back(mk(K_RET, 1'b0, 32'h0, 32'hDEADBEEF));
    exp1_q.push_back(mk(K_RD, 1'b0, 32'h41, 32'h0));
    exp1_q.push_back(mk(K_RET, 1'b1, 32'h0, 32'hDEADBEEF));
    b_m0_rd = 1'b1; b_m0_addr = 32'h40;
    b_m1_rd = 1'b1; b_m1_addr = 32'h41;
    settle(1);
    b_m0_rd = 1'b0; b_m1_rd = 1'b0;
    settle(30);

    // Nothing expected may remain outstanding.
    chk("a_queue_empty", EW'(exp_q.size()), '0);
    chk("b_queue_empty", EW'(exp1_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
